// File: rtl/div_seq.sv
// Sequential restoring divider for DIV/DIVU; one quotient bit per cycle on operand magnitudes.
// Latency: WIDTH cycles from the acceptance edge to the done pulse; q/r/div_zero registered.
// Backpressure: start is ignored while busy=1 (no queuing); a start during the done cycle is accepted.
//
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   start, signed_op  request (accepted when busy=0) and signed/unsigned mode
//   dividend, divisor operands, sampled only at the acceptance edge
//   q, r              quotient / remainder, held until the next operation completes
//   busy, done        iterating flag, one-cycle completion pulse
//   div_zero          completed operation had a zero divisor
module div_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;     // partial remainder
  logic [WIDTH-1:0] quo_q, quo_d;     // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs_q, dvs_d;     // divisor magnitude
  logic [WIDTH-1:0] dvd_q, dvd_d;     // original dividend, returned as r on divide-by-zero
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] qres_q, qres_d;
  logic [WIDTH-1:0] rres_q, rres_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  // One restoring step. The trial difference is one bit wider than the
  // partial remainder so its MSB is the borrow (negative result).
  logic [WIDTH+1:0] trial_w;
  logic [WIDTH:0]   shifted_w;
  logic [WIDTH:0]   rem_step;
  logic [WIDTH-1:0] quo_step;

  always_comb begin
    shifted_w = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    trial_w   = {rem_q, quo_q[WIDTH-1]} - {2'b00, dvs_q};
    rem_step  = trial_w[WIDTH+1] ? shifted_w : trial_w[WIDTH:0];
    quo_step  = {quo_q[WIDTH-2:0], ~trial_w[WIDTH+1]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    dvd_d   = dvd_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    zero_d  = zero_q;
    qres_d  = qres_q;
    rres_d  = rres_q;
    dz_d    = dz_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          quo_d   = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
          dvs_d   = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;
          dvd_d   = dividend;
          negq_d  = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          negr_d  = signed_op & dividend[WIDTH-1];
          zero_d  = (divisor == '0);
          rem_d   = '0;
          cnt_d   = CNT_W'(WIDTH);
        end
      end
      RUN: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          // Last step: write back directly from this step's result.
          state_d = IDLE;
          done_d  = 1'b1;
          dz_d    = zero_q;
          if (zero_q) begin
            qres_d = '1;
            rres_d = dvd_q;
          end else begin
            qres_d = negq_q ? -quo_step : quo_step;
            rres_d = negr_q ? -rem_step[WIDTH-1:0] : rem_step[WIDTH-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      dvd_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      zero_q  <= 1'b0;
      qres_q  <= '0;
      rres_q  <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      dvd_q   <= dvd_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      zero_q  <= zero_d;
      qres_q  <= qres_d;
      rres_q  <= rres_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign q        = qres_q;
  assign r        = rres_q;
  assign busy     = (state_q == RUN);
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed testbench for div_seq with hand-computed expected results.
// Latency: checks done exactly 32 cycles after acceptance.
// Backpressure: exercises ignored mid-operation starts and back-to-back acceptance.
module tb_div_seq;

  logic        clock;
  logic        reset;
  logic        start;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] q;
  logic [31:0] r;
  logic        busy;
  logic        done;
  logic        div_zero;

  int          n_checks;
  int          n_errors;
  logic [31:0] last_q;

  div_seq #(.WIDTH(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .signed_op (signed_op),
    .dividend  (dividend),
    .divisor   (divisor),
    .q         (q),
    .r         (r),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Issues one operation from the current (between-edge) time, scrambles the
  // operand inputs after acceptance and waits for done with a cycle budget.
  // With poke=1 a second start with other operands is pulsed mid-operation.
  task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_q,
                        input logic [31:0] exp_r, input logic exp_dz, input logic poke);
    int cycles;
    start     = 1'b1;
    signed_op = sgn;
    dividend  = a;
    divisor   = b;
    @(posedge clock);
    #1;
    start     = 1'b0;
    signed_op = ~sgn;
    dividend  = 32'h5A5A_5A5A;
    divisor   = 32'h0000_0003;
    check({tag, " busy@accept"}, busy, 1'b1);
    check({tag, " q held"}, q, last_q);
    cycles = 0;
    while (!done && cycles < 100) begin
      @(posedge clock);
      #1;
      cycles++;
      if (poke && cycles == 5) begin
        start     = 1'b1;
        signed_op = 1'b1;
        dividend  = 32'd999;
        divisor   = 32'd3;
      end
      if (poke && cycles == 6) start = 1'b0;
    end
    check({tag, " latency"}, cycles, 32);
    check({tag, " busy@done"}, busy, 1'b0);
    check({tag, " q"}, q, exp_q);
    check({tag, " r"}, r, exp_r);
    check({tag, " div_zero"}, div_zero, exp_dz);
    last_q = exp_q;
  endtask

  initial begin
    int seen;
    n_checks  = 0;
    n_errors  = 0;
    last_q    = 32'h0;
    reset     = 1'b1;
    start     = 1'b0;
    signed_op = 1'b0;
    dividend  = 32'h0;
    divisor   = 32'h0;
    #1;
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst q", q, 32'h0);
    check("rst r", r, 32'h0);
    check("rst div_zero", div_zero, 1'b0);
    #11;
    reset = 1'b0;
    idle(2);

    run_op("udiv", 1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 32'h0000_000F, 1'b0, 1'b0);
    idle(1);
    check("done one cycle", done, 1'b0);

    // Signed sign combinations, issued back-to-back on the done cycle.
    run_op("m7/2", 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("7/m2", 1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, 1'b0, 1'b0);
    run_op("m7/m2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 1'b0, 1'b0);
    idle(3);

    run_op("ovf s", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0);
    run_op("ovf u", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0);
    idle(2);

    run_op("div0", 1'b1, 32'd100, 32'd0, 32'hFFFF_FFFF, 32'h0000_0064, 1'b1, 1'b0);
    run_op("100/7", 1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
    idle(1);

    run_op("poke", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 1'b1);
    idle(2);

    // Reset asserted asynchronously ten cycles into RUN.
    start     = 1'b1;
    signed_op = 1'b0;
    dividend  = 32'h1234_5678;
    divisor   = 32'h0000_0010;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("arst busy", busy, 1'b0);
    check("arst done", done, 1'b0);
    check("arst q", q, 32'h0);
    check("arst r", r, 32'h0);
    check("arst div_zero", div_zero, 1'b0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (done) seen++;
      if (i == 2) reset = 1'b0;
    end
    check("no done after abort", seen, 0);
    last_q = 32'h0;

    run_op("fresh", 1'b0, 32'h1234_5678, 32'h0000_0010, 32'h0123_4567, 32'h0000_0008, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
